kv_cache_ring: RTL
==================

KV_CACHE_RING -- requirements
Module: kv_cache_ring

Interface
REQ-001 SHALL have parameter N_LAYERS, default 4: number of transformer layers.
REQ-002 SHALL have parameter N_HEADS, default 8: attention heads per layer.
REQ-003 SHALL have parameter MAX_POS, default 256: positions per layer ring; power of two, at least 2.
REQ-004 SHALL have parameter HEAD_DIM, default 16: elements per head vector; power of two.
REQ-005 SHALL have parameter DATA_W, default 8: element width.
REQ-006 SHALL have port clk_i, input, 1 bit: single clock; all logic on its rising edge.
REQ-007 SHALL have port rst_ni, input, 1 bit: reset, asynchronous assert, active-low.
REQ-008 SHALL have write-port inputs:
- wr_valid_i, 1 bit.
- wr_layer_i, clog2(N_LAYERS) bits.
- wr_kv_sel_i, 1 bit: 0 = K, 1 = V.
- wr_head_i, clog2(N_HEADS) bits.
- wr_dim_i, clog2(HEAD_DIM) bits.
- wr_data_i, DATA_W bits.
REQ-009 SHALL have output wr_ready_o, 1 bit: write beat accepted.
REQ-010 SHALL have commit inputs:
- commit_i, 1 bit: close the current token.
- commit_layer_i, clog2(N_LAYERS) bits.
REQ-011 SHALL have input clear_i, 1 bit: synchronous flush of all layers.
REQ-012 SHALL have read-port inputs:
- rd_en_i, 1 bit.
- rd_layer_i, rd_kv_sel_i, rd_head_i, rd_dim_i: same widths as the write port.
- rd_pos_i, clog2(MAX_POS) bits: logical position, where 0 is the oldest stored token.
REQ-013 SHALL have read outputs:
- rd_valid_o, 1 bit.
- rd_data_o, DATA_W bits.
- rd_oob_o, 1 bit: rd_pos_i was at or beyond the stored length.
REQ-014 SHALL have outputs:
- len_o, N_LAYERS*clog2(MAX_POS+1) bits: per-layer stored length, layer 0 in the LSBs.
- ovf_o, 1 bit: sticky error flag.

Function
REQ-015 SHALL keep, per layer, a write pointer wp (physical position) and a count cnt (0..MAX_POS).
REQ-016 SHALL accept a write beat when wr_valid_i and wr_ready_o are both high, storing wr_data_i at physical position wp[wr_layer_i] and the given kv_sel, head and dim; a beat does not advance wp.
REQ-017 SHALL, on commit_i, set wp[commit_layer_i] to (wp+1) mod MAX_POS and cnt to min(cnt+1, MAX_POS).
REQ-018 SHALL drive wr_ready_o combinationally high unless blocked per REQ-029.
REQ-019 SHALL, on rd_en_i, compute physical position (wp - cnt + rd_pos_i) mod MAX_POS from the pointers as they stand in the issue cycle, before any same-cycle commit.
REQ-020 SHALL have fixed read latency 2: rd_valid_o is high exactly 2 cycles after rd_en_i; back-to-back reads pipeline at one per cycle.
REQ-021 SHALL, when rd_pos_i >= cnt at issue, return rd_data_o = 0 with rd_oob_o = 1 alongside rd_valid_o.
REQ-022 SHALL, when a read and a write target the same cell in the same cycle, return the old data (read-first).
REQ-023 SHALL, on clear_i, zero every wp and cnt and ovf_o; memory contents are retained.
REQ-024 SHALL apply clear_i before a same-cycle commit; a same-cycle write beat is still stored.
REQ-025 SHALL keep a commit to one layer from affecting the pointers of any other layer.
REQ-026 SHALL hold rd_data_o and rd_oob_o stable between valid pulses.

Reset
REQ-027 SHALL, while rst_ni is low, force to zero: wp, cnt, rd_valid_o, rd_oob_o, rd_data_o, ovf_o and the read pipeline; memory is not initialised.
REQ-028 SHALL, on reset during an in-flight read, produce no rd_valid_o pulse for that read.

Configuration
REQ-029 SHALL support macro KV_CACHE_RING_WRAP_EN:
- Defined: the cache is a sliding window. A commit at cnt = MAX_POS overwrites the oldest token; cnt stays MAX_POS and the base advances. wr_ready_o is constantly 1 and ovf_o stays 0.
- Undefined: with cnt[wr_layer_i] = MAX_POS, wr_ready_o is 0. A commit at cnt = MAX_POS is ignored and sets ovf_o until clear_i or reset.

Verification
REQ-030 SHALL check: write 0xA5 to L0/K/H0/D0, commit L0, read pos 0 -> rd_valid_o at +2 cycles, data 0xA5, oob 0, len L0 = 1.
REQ-031 SHALL check: 16 beats to L1/V/H3 with data dim+10, commit, 16 back-to-back reads -> 10..25 on 16 consecutive cycles.
REQ-032 SHALL check isolation: 0x11 to L0 H0, 0x22 to L0 H1, 0xAA to L2 K, 0x55 to L2 V, 0xFF to L3 -> each reads back its own value; lengths of untouched layers stay 0.
REQ-033 SHALL check: read pos 3 with cnt = 3 -> rd_data_o 0, rd_oob_o 1.
REQ-034 SHALL check, with MAX_POS = 4, six tokens with data 1..6 committed to L0 (WRAP_EN) -> logical pos 0..3 read 3,4,5,6 and len = 4; without WRAP_EN -> wr_ready_o 0 after 4, ovf_o 1 after the 5th commit.
REQ-035 SHALL check: rst_ni pulled low one cycle after rd_en_i -> no rd_valid_o and all len_o 0; clear_i concurrent with commit -> len = 0.

Source files
------------

// File: rtl/kv_cache_ring.sv
// kv_cache_ring: per-layer ring buffer of attention K/V head vectors.
// Optional sliding-window mode is enabled by defining KV_CACHE_RING_WRAP_EN.
module kv_cache_ring #(
    parameter  int N_LAYERS = 4,
    parameter  int N_HEADS  = 8,
    parameter  int MAX_POS  = 256,
    parameter  int HEAD_DIM = 16,
    parameter  int DATA_W   = 8,
    localparam int LW = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1,
    localparam int HW = (N_HEADS > 1) ? $clog2(N_HEADS) : 1,
    localparam int DW = (HEAD_DIM > 1) ? $clog2(HEAD_DIM) : 1,
    localparam int PW = $clog2(MAX_POS),
    localparam int CW = $clog2(MAX_POS + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   wr_valid_i,
    input  logic [LW-1:0]          wr_layer_i,
    input  logic                   wr_kv_sel_i,
    input  logic [HW-1:0]          wr_head_i,
    input  logic [DW-1:0]          wr_dim_i,
    input  logic [DATA_W-1:0]      wr_data_i,
    output logic                   wr_ready_o,
    input  logic                   commit_i,
    input  logic [LW-1:0]          commit_layer_i,
    input  logic                   clear_i,
    input  logic                   rd_en_i,
    input  logic [LW-1:0]          rd_layer_i,
    input  logic                   rd_kv_sel_i,
    input  logic [HW-1:0]          rd_head_i,
    input  logic [DW-1:0]          rd_dim_i,
    input  logic [PW-1:0]          rd_pos_i,
    output logic                   rd_valid_o,
    output logic [DATA_W-1:0]      rd_data_o,
    output logic                   rd_oob_o,
    output logic [N_LAYERS*CW-1:0] len_o,
    output logic                   ovf_o
);

    localparam int AW = LW + 1 + HW + PW + DW;
    localparam logic [CW-1:0] FULL = CW'(MAX_POS);

    logic [PW-1:0]     r_wp  [N_LAYERS];
    logic [CW-1:0]     r_cnt [N_LAYERS];
    logic              r_ovf;
    logic [DATA_W-1:0] r_mem [2**AW];

    logic              r_s1_valid;
    logic              r_s1_oob;
    logic [DATA_W-1:0] r_s1_data;

    logic              w_wr_fire;
    logic [AW-1:0]     w_wr_addr;
    logic              w_cm_full;
    logic [PW-1:0]     w_rd_wp;
    logic [CW-1:0]     w_rd_cnt;
    logic [PW-1:0]     w_rd_phys;
    logic              w_rd_oob;
    logic [AW-1:0]     w_rd_addr;

    // Write side: beats land at the layer's current write pointer.
`ifdef KV_CACHE_RING_WRAP_EN
    assign wr_ready_o = 1'b1;
`else
    logic w_wr_full;
    assign w_wr_full  = (r_cnt[wr_layer_i] == FULL);
    assign wr_ready_o = ~w_wr_full;
`endif

    assign w_wr_fire = wr_valid_i & wr_ready_o;
    assign w_wr_addr = {wr_layer_i, wr_kv_sel_i, wr_head_i,
                        r_wp[wr_layer_i], wr_dim_i};
    assign w_cm_full = (r_cnt[commit_layer_i] == FULL);

    // Read side: map logical position (0 = oldest) to physical slot.
    assign w_rd_wp   = r_wp[rd_layer_i];
    assign w_rd_cnt  = r_cnt[rd_layer_i];
    assign w_rd_phys = w_rd_wp - w_rd_cnt[PW-1:0] + rd_pos_i;
    assign w_rd_oob  = (CW'(rd_pos_i) >= w_rd_cnt);
    assign w_rd_addr = {rd_layer_i, rd_kv_sel_i, rd_head_i,
                        w_rd_phys, rd_dim_i};

    // Per-layer pointer/count update; clear overrides a same-cycle commit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < N_LAYERS; i++) begin
                r_wp[i]  <= '0;
                r_cnt[i] <= '0;
            end
            r_ovf <= 1'b0;
        end else if (clear_i) begin
            for (int i = 0; i < N_LAYERS; i++) begin
                r_wp[i]  <= '0;
                r_cnt[i] <= '0;
            end
            r_ovf <= 1'b0;
        end else if (commit_i) begin
            if (w_cm_full) begin
`ifdef KV_CACHE_RING_WRAP_EN
                r_wp[commit_layer_i] <= r_wp[commit_layer_i] + 1'b1;
`else
                r_ovf <= 1'b1;
`endif
            end else begin
                r_wp[commit_layer_i]  <= r_wp[commit_layer_i] + 1'b1;
                r_cnt[commit_layer_i] <= r_cnt[commit_layer_i] + 1'b1;
            end
        end
    end

    // Storage array; contents survive reset and clear.
    always_ff @(posedge clk_i) begin
        if (w_wr_fire) begin
            r_mem[w_wr_addr] <= wr_data_i;
        end
    end

    // Read stage 1: sample memory in the issue cycle (read-first).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s1_valid <= 1'b0;
            r_s1_oob   <= 1'b0;
            r_s1_data  <= '0;
        end else begin
            r_s1_valid <= rd_en_i;
            if (rd_en_i) begin
                r_s1_oob  <= w_rd_oob;
                r_s1_data <= r_mem[w_rd_addr];
            end
        end
    end

    // Read stage 2: registered outputs, held between valid pulses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_valid_o <= 1'b0;
            rd_oob_o   <= 1'b0;
            rd_data_o  <= '0;
        end else begin
            rd_valid_o <= r_s1_valid;
            if (r_s1_valid) begin
                rd_oob_o  <= r_s1_oob;
                rd_data_o <= r_s1_oob ? '0 : r_s1_data;
            end
        end
    end

    for (genvar g = 0; g < N_LAYERS; g++) begin : g_len
        assign len_o[g*CW +: CW] = r_cnt[g];
    end

    assign ovf_o = r_ovf;

endmodule
